sa_ctrl_8bit: RTL and testbench

SA_CTRL_8BIT -- requirements
Module: sa_ctrl_8bit

---
 rtl/sa_pkg.sv | 15 +
 rtl/sa_skew_line.sv | 26 ++
 rtl/sa_ctrl_8bit.sv | 150 +++++++++++++++
 tb/tb_sa_ctrl_8bit.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sa_pkg.sv
// Shared types and default sizing for the systolic-array controller.
package sa_pkg;

  localparam int unsigned DefN  = 8;
  localparam int unsigned DefLw = 8;

  typedef enum logic [2:0] {
    StIdle,
    StLoadW,
    StStream,
    StDrain,
    StDone
  } sa_state_e;

endpackage

// File: rtl/sa_skew_line.sv
// Fixed-depth 1-bit delay line with asynchronous clear.
module sa_skew_line #(
  parameter int unsigned DEPTH = 1
) (
  input  logic I_CLK,
  input  logic I_RST_N,
  input  logic I_IN,
  output logic O_OUT
);

  logic [DEPTH-1:0] sr_q;

  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      sr_q <= '0;
    end else begin
      sr_q[0] <= I_IN;
      for (int i = 1; i < DEPTH; i++) begin
        sr_q[i] <= sr_q[i-1];
      end
    end
  end

  assign O_OUT = sr_q[DEPTH-1];

endmodule

// File: rtl/sa_ctrl_8bit.sv
// Sequencer for one N x N systolic pass: weight load, vector stream, drain.
// Optional busy-cycle counter enabled by defining SA_CTRL_PERF_EN.
module sa_ctrl_8bit
  import sa_pkg::*;
#(
  parameter int unsigned N  = DefN,
  parameter int unsigned LW = DefLw
) (
  input  logic              I_CLK,
  input  logic              I_RST_N,
  input  logic              I_START,
  input  logic [LW-1:0]     I_LEN,
  output logic              O_W_WE,
  output logic [$clog2(N)-1:0] O_W_ROW,
  output logic              O_X_RD,
  output logic [LW-1:0]     O_X_IDX,
  output logic [N-1:0]      O_X_VALID,
  output logic [N-1:0]      O_OUT_VALID,
  output logic              O_BUSY,
  output logic              O_DONE
`ifdef SA_CTRL_PERF_EN
  ,
  output logic [15:0]       O_CYC_CNT
`endif
);

  localparam int unsigned RW = $clog2(N);
  localparam int unsigned PW = $clog2(2 * N);

  sa_state_e       state_q, state_d;
  logic [PW-1:0]   phase_q, phase_d;
  logic [LW-1:0]   vec_q, vec_d;
  logic [LW-1:0]   len_q, len_d;
  logic            accept;

  assign accept = (state_q == StIdle) && I_START && (I_LEN != '0);

  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      state_q <= StIdle;
      phase_q <= '0;
      vec_q   <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      vec_q   <= vec_d;
      len_q   <= len_d;
    end
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    vec_d   = vec_q;
    len_d   = len_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StLoadW;
          len_d   = I_LEN;
          phase_d = '0;
        end
      end
      StLoadW: begin
        if (phase_q == PW'(N - 1)) begin
          state_d = StStream;
          phase_d = '0;
          vec_d   = '0;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      StStream: begin
        if (vec_q == len_q - 1'b1) begin
          state_d = StDrain;
          vec_d   = '0;
        end else begin
          vec_d = vec_q + 1'b1;
        end
      end
      StDrain: begin
        // Drain long enough for the last vector to leave the far column.
        if (phase_q == PW'(2 * N - 1)) begin
          state_d = StDone;
          phase_d = '0;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign O_W_WE  = (state_q == StLoadW);
  assign O_W_ROW = O_W_WE ? phase_q[RW-1:0] : '0;
  assign O_X_RD  = (state_q == StStream);
  assign O_X_IDX = O_X_RD ? vec_q : '0;
  assign O_BUSY  = (state_q != StIdle);
  assign O_DONE  = (state_q == StDone);

  // Row 0 valid follows the 1-cycle buffer read latency; other taps skew from it.
  sa_skew_line #(.DEPTH(1)) u_xv0 (
    .I_CLK   (I_CLK),
    .I_RST_N (I_RST_N),
    .I_IN    (O_X_RD),
    .O_OUT   (O_X_VALID[0])
  );

  for (genvar r = 1; r < N; r++) begin : g_xv
    sa_skew_line #(.DEPTH(r)) u_xv (
      .I_CLK   (I_CLK),
      .I_RST_N (I_RST_N),
      .I_IN    (O_X_VALID[0]),
      .O_OUT   (O_X_VALID[r])
    );
  end

  for (genvar c = 0; c < N; c++) begin : g_ov
    sa_skew_line #(.DEPTH(N + c)) u_ov (
      .I_CLK   (I_CLK),
      .I_RST_N (I_RST_N),
      .I_IN    (O_X_VALID[0]),
      .O_OUT   (O_OUT_VALID[c])
    );
  end

`ifdef SA_CTRL_PERF_EN
  logic [15:0] cyc_cnt_q;

  // The DONE cycle itself is not counted, so the value is final while O_DONE is high.
  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      cyc_cnt_q <= '0;
    end else if (accept) begin
      cyc_cnt_q <= '0;
    end else if ((state_q inside {StLoadW, StStream, StDrain}) && (cyc_cnt_q != 16'hFFFF)) begin
      cyc_cnt_q <= cyc_cnt_q + 16'd1;
    end
  end

  assign O_CYC_CNT = cyc_cnt_q;
`endif

endmodule

// File: tb/tb_sa_ctrl_8bit.sv
// Randomised scoreboard bench for sa_ctrl_8bit; expectations come from a pass-timing model.
module tb_sa_ctrl_8bit;

  localparam int N  = 4;
  localparam int LW = 8;

  logic                 I_CLK   = 1'b0;
  logic                 I_RST_N = 1'b0;
  logic                 I_START = 1'b0;
  logic [LW-1:0]        I_LEN   = '0;
  logic                 O_W_WE;
  logic [$clog2(N)-1:0] O_W_ROW;
  logic                 O_X_RD;
  logic [LW-1:0]        O_X_IDX;
  logic [N-1:0]         O_X_VALID;
  logic [N-1:0]         O_OUT_VALID;
  logic                 O_BUSY;
  logic                 O_DONE;
`ifdef SA_CTRL_PERF_EN
  logic [15:0]          O_CYC_CNT;
`endif

  sa_ctrl_8bit #(.N(N), .LW(LW)) dut (
    .I_CLK       (I_CLK),
    .I_RST_N     (I_RST_N),
    .I_START     (I_START),
    .I_LEN       (I_LEN),
    .O_W_WE      (O_W_WE),
    .O_W_ROW     (O_W_ROW),
    .O_X_RD      (O_X_RD),
    .O_X_IDX     (O_X_IDX),
    .O_X_VALID   (O_X_VALID),
    .O_OUT_VALID (O_OUT_VALID),
    .O_BUSY      (O_BUSY),
    .O_DONE      (O_DONE)
`ifdef SA_CTRL_PERF_EN
    ,
    .O_CYC_CNT   (O_CYC_CNT)
`endif
  );

  always #5 I_CLK = ~I_CLK;

  int cyc = 0;
  always @(posedge I_CLK) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int cyc;
    int val;
  } ev_t;

  ev_t        w_q[$];
  ev_t        x_q[$];
  ev_t        d_q[$];
  bit [N-1:0] exp_xv[int];
  bit [N-1:0] exp_ov[int];
  bit         exp_busy[int];
  int         idle_from = 32'h4000_0000;
  bit         have_pass = 1'b0;
  int         last_cnt  = 0;

  function automatic void chk(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, exp);
    end
  endfunction

  // A pass started (I_START high) in cycle s: N weight writes, len reads, 2N drain, DONE.
  function automatic void model_start(int s, int len);
    int         d;
    int         c;
    bit [N-1:0] v;
    if (len == 0 || s < idle_from) return;
    d = s + 3 * N + len + 1;
    for (int r = 0; r < N; r++) w_q.push_back('{s + 1 + r, r});
    for (int i = 0; i < len; i++) begin
      x_q.push_back('{s + N + 1 + i, i});
      for (int r = 0; r < N; r++) begin
        c = s + N + 2 + i + r;
        v = exp_xv.exists(c) ? exp_xv[c] : '0;
        v[r] = 1'b1;
        exp_xv[c] = v;
        c = s + 2 * N + 2 + i + r;
        v = exp_ov.exists(c) ? exp_ov[c] : '0;
        v[r] = 1'b1;
        exp_ov[c] = v;
      end
    end
    for (int k = s + 1; k <= d; k++) exp_busy[k] = 1'b1;
    d_q.push_back('{d, 3 * N + len});
    idle_from = d + 1;
  endfunction

  function automatic void model_reset();
    w_q.delete();
    x_q.delete();
    d_q.delete();
    exp_xv.delete();
    exp_ov.delete();
    exp_busy.delete();
    idle_from = 32'h4000_0000;
    have_pass = 1'b0;
  endfunction

  task automatic monitor();
    ev_t e;
    while (w_q.size() > 0 && w_q[0].cyc < cyc) begin
      e = w_q.pop_front();
      chk("w_we_missed_cyc", cyc, e.cyc);
    end
    while (x_q.size() > 0 && x_q[0].cyc < cyc) begin
      e = x_q.pop_front();
      chk("x_rd_missed_cyc", cyc, e.cyc);
    end
    while (d_q.size() > 0 && d_q[0].cyc < cyc) begin
      e = d_q.pop_front();
      chk("done_missed_cyc", cyc, e.cyc);
    end
    if (O_W_WE) begin
      if (w_q.size() == 0) chk("w_we_extra", O_W_WE, 0);
      else begin
        e = w_q.pop_front();
        chk("w_we_cyc", cyc, e.cyc);
        chk("w_row", O_W_ROW, e.val);
      end
    end else chk("w_row_idle", O_W_ROW, 0);
    if (O_X_RD) begin
      if (x_q.size() == 0) chk("x_rd_extra", O_X_RD, 0);
      else begin
        e = x_q.pop_front();
        chk("x_rd_cyc", cyc, e.cyc);
        chk("x_idx", O_X_IDX, e.val);
      end
    end else chk("x_idx_idle", O_X_IDX, 0);
    if (O_DONE) begin
      if (d_q.size() == 0) chk("done_extra", O_DONE, 0);
      else begin
        e = d_q.pop_front();
        chk("done_cyc", cyc, e.cyc);
`ifdef SA_CTRL_PERF_EN
        chk("cyc_cnt", O_CYC_CNT, e.val);
        last_cnt  = e.val;
        have_pass = 1'b1;
`endif
      end
    end
`ifdef SA_CTRL_PERF_EN
    if (have_pass && !O_BUSY) chk("cyc_cnt_hold", O_CYC_CNT, last_cnt);
`endif
    chk("x_valid", O_X_VALID, exp_xv.exists(cyc) ? exp_xv[cyc] : '0);
    chk("out_valid", O_OUT_VALID, exp_ov.exists(cyc) ? exp_ov[cyc] : '0);
    chk("busy", O_BUSY, exp_busy.exists(cyc) ? 1 : 0);
  endtask

  initial begin
    forever begin
      @(negedge I_CLK);
      monitor();
    end
  end

  task automatic tick();
    @(posedge I_CLK);
    #1;
  endtask

  task automatic drive(bit st, int len);
    I_START = st;
    I_LEN   = len[LW-1:0];
    if (st) model_start(cyc, len);
  endtask

  task automatic wait_idle();
    drive(1'b0, 0);
    while (cyc < idle_from) tick();
  endtask

  task automatic check_zero(string tag);
    chk({tag, "_w_we"}, O_W_WE, 0);
    chk({tag, "_w_row"}, O_W_ROW, 0);
    chk({tag, "_x_rd"}, O_X_RD, 0);
    chk({tag, "_x_idx"}, O_X_IDX, 0);
    chk({tag, "_x_valid"}, O_X_VALID, 0);
    chk({tag, "_out_valid"}, O_OUT_VALID, 0);
    chk({tag, "_busy"}, O_BUSY, 0);
    chk({tag, "_done"}, O_DONE, 0);
  endtask

  int s;

  initial begin
    repeat (3) tick();
    check_zero("rst");
    I_RST_N   = 1'b1;
    idle_from = cyc + 1;
    tick();

    // Reference pass with stray starts in STREAM (k=6) and DRAIN (k=11).
    drive(1'b1, 3);
    for (int k = 1; k <= 20; k++) begin
      tick();
      drive(k == 6 || k == 11, 7);
    end
    drive(1'b0, 0);

    // Zero-length start is ignored.
    tick();
    drive(1'b1, 0);
    tick();
    drive(1'b0, 0);
    repeat (4) tick();

    // Start in the first IDLE cycle after DONE.
    drive(1'b1, 2);
    tick();
    wait_idle();
    drive(1'b1, 1);
    tick();
    wait_idle();

    // Longest pass.
    drive(1'b1, 255);
    tick();
    wait_idle();
    tick();

    // Reset in the middle of STREAM, then a clean pass.
    drive(1'b1, 5);
    s = cyc;
    tick();
    drive(1'b0, 0);
    while (cyc < s + N + 3) tick();
    I_RST_N = 1'b0;
    model_reset();
    #1;
    check_zero("midrst");
    tick();
    tick();
    I_RST_N   = 1'b1;
    idle_from = cyc + 1;
    tick();
    drive(1'b1, 3);
    tick();
    wait_idle();

    // Random starts, lengths and spacing.
    repeat (600) begin
      drive(($urandom % 6) == 0, $urandom_range(0, 12));
      tick();
    end
    wait_idle();
    repeat (4) tick();

    chk("w_q_left", w_q.size(), 0);
    chk("x_q_left", x_q.size(), 0);
    chk("d_q_left", d_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
